i2c_reg_sequencer: RTL and testbench
====================================

Name: i2c_reg_sequencer

Overview:
- Sequences register-file accesses behind the I2C subordinate interface.
- Consumes byte-level events from the I2C target (start/repeated-start with R/W bit, received bytes, transmit-byte requests, master NACK, stop).
- Maintains a register pointer and issues read/write requests on a simple req/ack register bus.
- Drives hold_clock_low to stretch SCL while a bus access is outstanding.

Parameters:
- ADDR_W, 8, register pointer and bus address width; pointer wraps modulo 2**ADDR_W.
- TIMEOUT, 255, maximum clk cycles to wait for reg_ack before abort; counter width is clog2(TIMEOUT+1).
- AUTO_INC, 1, when 1 the pointer increments after each data byte; when 0 the pointer stays fixed.

Ports:
- clk  input  1  system clock; all I2C event inputs are already synchronized to clk.
- rst_n  input  1  reset, asynchronous, active-low.
- txn_start  input  1  1-cycle pulse: address matched after START or repeated START.
- txn_rw  input  1  R/W bit, valid with txn_start; 1 = read.
- txn_stop  input  1  1-cycle pulse: STOP detected.
- rx_valid  input  1  1-cycle pulse: byte received from master.
- rx_byte  input  8  received byte, valid with rx_valid.
- tx_req  input  1  1-cycle pulse: I2C side is consuming tx_byte now.
- rx_nack  input  1  1-cycle pulse: master NACKed the last read byte.
- tx_byte  output  8  byte presented for the next read transfer.
- tx_valid  output  1  tx_byte holds fresh data.
- hold_clock_low  output  1  request SCL stretch.
- reg_req  output  1  bus request.
- reg_we  output  1  1 = write.
- reg_addr  output  ADDR_W  bus address.
- reg_wdata  output  8  write data.
- reg_ack  input  1  1-cycle completion; sampled only while reg_req = 1.
- reg_rdata  input  8  read data, valid with reg_ack.
- err_timeout  output  1  sticky; cleared by the next txn_start.
- err_overrun  output  1  sticky; cleared by the next txn_start.

Behaviour:
- Reset values: all outputs 0, pointer 0, state IDLE.
- States:
  - IDLE
  - W_PTR: await pointer byte
  - W_DATA: await data byte
  - W_BUS: write outstanding
  - R_FETCH: read outstanding
  - R_READY: tx_valid = 1, awaiting tx_req
  - R_DONE: NACK received; await stop or start
- IDLE/any state + txn_start:
  - rw = 0 → W_PTR.
  - rw = 1 → R_FETCH at the current pointer.
  - The pointer survives repeated start.
- W_PTR + rx_valid: pointer ← rx_byte[ADDR_W-1:0] → W_DATA.
- W_DATA + rx_valid:
  - Register the byte.
  - Next cycle: reg_req = 1, reg_we = 1, addr = pointer → W_BUS.
- W_BUS + reg_ack: pointer += AUTO_INC → W_DATA.
- R_FETCH:
  - reg_req = 1, reg_we = 0.
  - On reg_ack: tx_byte ← reg_rdata, tx_valid = 1, pointer += AUTO_INC → R_READY.
- R_READY:
  - tx_req: tx_valid ← 0 next cycle → R_FETCH (prefetch the next byte).
  - rx_nack: → R_DONE; no further fetch.
- reg_req, reg_we, reg_addr and reg_wdata are stable from assertion until the cycle of reg_ack. reg_req deasserts the cycle after reg_ack.
- hold_clock_low:
  - 1 in W_BUS and R_FETCH.
  - 0 in every other state.
  - Registered, so it changes 1 cycle after the state change.
- Timeout:
  - The counter runs in W_BUS and R_FETCH.
  - When it reaches TIMEOUT: drop reg_req, release the stretch, set err_timeout, go to IDLE.
  - For a read timeout, tx_byte = 8'hFF with tx_valid = 0.
- txn_stop:
  - With no bus op outstanding: → IDLE.
  - With a bus op outstanding: complete the handshake (or time out) first, then go to IDLE.
  - Never drop reg_req before ack or timeout.
- rx_valid in W_BUS or R_*: byte dropped, err_overrun = 1.
- txn_start in the same cycle as reg_ack: the ack completes the current op first (pointer update applied), then the new transaction begins.
- Pointer wrap: 2**ADDR_W - 1 + 1 → 0.
- rst_n assertion mid-op: immediate return to reset values; reg_req drops asynchronously.

Decomposition:
- Package i2c_pkg:
  - State enum seq_state_t.
  - Byte width constant I2C_BYTE_W = 8.
  - Default TIMEOUT constant.
- Sub-module seq_timeout_ctr:
  - Load/enable counter.
  - Outputs an expired pulse.
  - Parameterised by TIMEOUT.

Test Plan:
- Write: start rw=0, bytes 8'h10, 8'hA5, 8'h5A → reg writes (10,A5) then (11,5A); hold_clock_low high only during each W_BUS; final pointer 8'h12.
- Read: pointer 8'h20 set, repeated start rw=1, regs 20=8'h3C / 21=8'hC3 → tx_byte 3C then C3 on successive tx_req; rx_nack after the second byte → R_DONE, no third reg_req.
- Wrap: pointer 8'hFF, write one byte → access at FF, pointer becomes 8'h00.
- Timeout: reg_ack never asserted → after 255 cycles reg_req = 0, hold_clock_low = 0, err_timeout = 1; next txn_start clears it.
- Stop during W_BUS with ack delayed 10 cycles → reg_req held until ack, then IDLE; overrun byte injected during W_BUS sets err_overrun.
- Reset asserted mid R_FETCH → all outputs 0 immediately; the next read starts at pointer 0.

Source files
------------

// File: rtl/i2c_pkg.sv
// i2c_pkg: shared state encoding, pending-event codes and defaults for the I2C register sequencer
package i2c_pkg;
  localparam int I2C_BYTE_W = 8;
  localparam int DEF_TIMEOUT = 255;
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_W_PTR   = 3'd1,
    S_W_DATA  = 3'd2,
    S_W_BUS   = 3'd3,
    S_R_FETCH = 3'd4,
    S_R_READY = 3'd5,
    S_R_DONE  = 3'd6
  } seq_state_t;
  localparam logic [1:0] P_NONE = 2'd0;
  localparam logic [1:0] P_STOP = 2'd1;
  localparam logic [1:0] P_WR   = 2'd2;
  localparam logic [1:0] P_RD   = 2'd3;
  function automatic logic is_bus_state(seq_state_t s);
    return (s == S_W_BUS) || (s == S_R_FETCH);
  endfunction
endpackage

// File: rtl/seq_timeout_ctr.sv
// seq_timeout_ctr: cycle counter for an outstanding bus access, pulses expired at TIMEOUT
module seq_timeout_ctr import i2c_pkg::*; #(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expired
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign expired = en && (cnt_q == CNT_W'(TIMEOUT));
  // restart on load or expiry so a follow-on access gets a full budget
  always_comb cnt_d = (load || expired) ? '0 : en ? cnt_q + 1'b1 : cnt_q;
  // counter register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/i2c_reg_sequencer.sv
// i2c_reg_sequencer: turns I2C target byte events into register-bus reads/writes with clock stretching
module i2c_reg_sequencer import i2c_pkg::*; #(
  parameter int ADDR_W   = 8,
  parameter int TIMEOUT  = DEF_TIMEOUT,
  parameter int AUTO_INC = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  txn_start,
  input  logic                  txn_rw,
  input  logic                  txn_stop,
  input  logic                  rx_valid,
  input  logic [I2C_BYTE_W-1:0] rx_byte,
  input  logic                  tx_req,
  input  logic                  rx_nack,
  output logic [I2C_BYTE_W-1:0] tx_byte,
  output logic                  tx_valid,
  output logic                  hold_clock_low,
  output logic                  reg_req,
  output logic                  reg_we,
  output logic [ADDR_W-1:0]     reg_addr,
  output logic [I2C_BYTE_W-1:0] reg_wdata,
  input  logic                  reg_ack,
  input  logic [I2C_BYTE_W-1:0] reg_rdata,
  output logic                  err_timeout,
  output logic                  err_overrun
);
  seq_state_t state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d, addr_q, addr_d;
  logic [I2C_BYTE_W-1:0] wdata_q, wdata_d, tx_byte_q, tx_byte_d;
  logic [1:0] pend_q, pend_d;
  logic req_q, req_d, we_q, we_d, tx_valid_q, tx_valid_d, hold_q, hold_d;
  logic err_to_q, err_to_d, err_ov_q, err_ov_d;
  logic expired, ack_v, to_v, done, start_ev, start_rd, stop_ev;

  seq_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_ctr (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (!req_q || reg_ack),
    .en      (req_q),
    .expired (expired)
  );

  assign ack_v    = req_q && reg_ack;
  assign to_v     = req_q && !reg_ack && expired;
  assign done     = ack_v || to_v;
  assign start_ev = txn_start || (done && pend_q[1]);
  assign start_rd = txn_start ? txn_rw : pend_q[0];
  assign stop_ev  = txn_stop || (done && pend_q == P_STOP);

  // next-state: finish any bus op first, then apply start/stop (live or deferred), then byte events
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    tx_byte_d = tx_byte_q;
    pend_d    = pend_q;
    req_d     = req_q;
    we_d      = we_q;
    err_to_d  = txn_start ? 1'b0 : err_to_q;
    err_ov_d  = txn_start ? 1'b0 : err_ov_q;
    if (rx_valid && state_q inside {S_W_BUS, S_R_FETCH, S_R_READY, S_R_DONE}) err_ov_d = 1'b1;
    if (ack_v) begin
      ptr_d   = ptr_q + ADDR_W'(AUTO_INC != 0);
      req_d   = 1'b0;
      state_d = we_q ? S_W_DATA : S_R_READY;
      if (!we_q) tx_byte_d = reg_rdata;
    end else if (to_v) begin
      req_d    = 1'b0;
      err_to_d = 1'b1;
      state_d  = S_IDLE;
      if (!we_q) tx_byte_d = 8'hFF;
    end
    if (req_q && !done) begin
      if (txn_start) pend_d = txn_rw ? P_RD : P_WR;
      else if (txn_stop) pend_d = P_STOP;
    end else begin
      pend_d = P_NONE;
      if (start_ev) begin
        state_d = start_rd ? S_R_FETCH : S_W_PTR;
        if (start_rd) begin
          req_d  = 1'b1;
          we_d   = 1'b0;
          addr_d = ptr_d;
        end
      end else if (stop_ev) begin
        state_d = S_IDLE;
      end else if (state_q == S_W_PTR && rx_valid) begin
        ptr_d   = ADDR_W'(rx_byte);
        state_d = S_W_DATA;
      end else if (state_q == S_W_DATA && rx_valid) begin
        wdata_d = rx_byte;
        req_d   = 1'b1;
        we_d    = 1'b1;
        addr_d  = ptr_q;
        state_d = S_W_BUS;
      end else if (state_q == S_R_READY && tx_req) begin
        req_d   = 1'b1;
        we_d    = 1'b0;
        addr_d  = ptr_q;
        state_d = S_R_FETCH;
      end else if (state_q == S_R_READY && rx_nack) begin
        state_d = S_R_DONE;
      end
    end
    tx_valid_d = state_d == S_R_READY;
    hold_d     = is_bus_state(state_q);
  end

  // state and output registers; reset clears everything including an in-flight request
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      tx_byte_q  <= '0;
      pend_q     <= P_NONE;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      tx_valid_q <= 1'b0;
      hold_q     <= 1'b0;
      err_to_q   <= 1'b0;
      err_ov_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      tx_byte_q  <= tx_byte_d;
      pend_q     <= pend_d;
      req_q      <= req_d;
      we_q       <= we_d;
      tx_valid_q <= tx_valid_d;
      hold_q     <= hold_d;
      err_to_q   <= err_to_d;
      err_ov_q   <= err_ov_d;
    end

  assign tx_byte        = tx_byte_q;
  assign tx_valid       = tx_valid_q;
  assign hold_clock_low = hold_q;
  assign reg_req        = req_q;
  assign reg_we         = we_q;
  assign reg_addr       = addr_q;
  assign reg_wdata      = wdata_q;
  assign err_timeout    = err_to_q;
  assign err_overrun    = err_ov_q;
endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// tb_i2c_reg_sequencer: directed scoreboard bench for the I2C register sequencer
module tb_i2c_reg_sequencer;
  logic clk = 1'b0, rst_n = 1'b0;
  logic txn_start = 1'b0, txn_rw = 1'b0, txn_stop = 1'b0, rx_valid = 1'b0, tx_req = 1'b0, rx_nack = 1'b0;
  logic reg_ack = 1'b0;
  logic [7:0] rx_byte = 8'h00, reg_rdata = 8'h00;
  logic [7:0] tx_byte, reg_addr, reg_wdata;
  logic tx_valid, hold_clock_low, reg_req, reg_we, err_timeout, err_overrun;

  typedef struct {
    logic       we;
    logic [7:0] addr;
    logic [7:0] data;
  } bus_t;

  bus_t exp_bus[$];
  logic [7:0] exp_tx[$];
  logic [7:0] mem[256];
  int checks = 0, failures = 0;
  int ack_delay = 0, wait_cnt = 0, ops = 0, hold_cnt = 0;
  bit ack_en = 1'b1;
  logic req_prev = 1'b0;

  always #5 clk = ~clk;

  i2c_reg_sequencer dut (
    .clk(clk), .rst_n(rst_n), .txn_start(txn_start), .txn_rw(txn_rw), .txn_stop(txn_stop),
    .rx_valid(rx_valid), .rx_byte(rx_byte), .tx_req(tx_req), .rx_nack(rx_nack),
    .tx_byte(tx_byte), .tx_valid(tx_valid), .hold_clock_low(hold_clock_low),
    .reg_req(reg_req), .reg_we(reg_we), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_ack(reg_ack), .reg_rdata(reg_rdata), .err_timeout(err_timeout), .err_overrun(err_overrun)
  );

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // register-bus responder: acks after ack_delay cycles and checks each access against the scoreboard
  always @(negedge clk) begin
    if (!rst_n) begin
      reg_ack = 1'b0;
      wait_cnt = 0;
    end else if (reg_ack) begin
      reg_ack = 1'b0;
    end else if (reg_req && ack_en) begin
      if (wait_cnt == ack_delay) begin
        bus_t e;
        wait_cnt = 0;
        reg_rdata = mem[reg_addr];
        reg_ack = 1'b1;
        chk("bus_expected", 32'(exp_bus.size() != 0), 1);
        if (exp_bus.size() != 0) begin
          e = exp_bus.pop_front();
          chk("bus_we", 32'(reg_we), 32'(e.we));
          chk("bus_addr", 32'(reg_addr), 32'(e.addr));
          if (e.we) begin
            chk("bus_wdata", 32'(reg_wdata), 32'(e.data));
            mem[reg_addr] = reg_wdata;
          end
        end
      end else wait_cnt++;
    end else wait_cnt = 0;
  end

  always @(negedge clk) begin
    if (rst_n && reg_req && !req_prev) ops++;
    if (hold_clock_low) hold_cnt++;
    req_prev = reg_req;
  end

  task automatic do_start(logic rw);
    @(negedge clk); txn_start = 1'b1; txn_rw = rw;
    @(negedge clk); txn_start = 1'b0;
  endtask
  task automatic do_stop();
    @(negedge clk); txn_stop = 1'b1;
    @(negedge clk); txn_stop = 1'b0;
  endtask
  task automatic do_byte(logic [7:0] b);
    @(negedge clk); rx_valid = 1'b1; rx_byte = b;
    @(negedge clk); rx_valid = 1'b0;
  endtask
  task automatic do_txreq();
    @(negedge clk); tx_req = 1'b1;
    @(negedge clk); tx_req = 1'b0;
  endtask
  task automatic do_nack();
    @(negedge clk); rx_nack = 1'b1;
    @(negedge clk); rx_nack = 1'b0;
  endtask
  task automatic push_bus(logic we, logic [7:0] a, logic [7:0] d);
    bus_t e;
    e.we = we; e.addr = a; e.data = d;
    exp_bus.push_back(e);
  endtask
  task automatic wait_bus(string tag);
    int n = 0;
    while (reg_req && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_req_released"}, 32'(reg_req), 0);
  endtask
  task automatic check_tx(string tag);
    logic [7:0] e;
    e = (exp_tx.size() != 0) ? exp_tx.pop_front() : 8'hxx;
    chk({tag, "_tx_valid"}, 32'(tx_valid), 1);
    chk({tag, "_tx_byte"}, 32'(tx_byte), 32'(e));
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
    mem[8'h12] = 8'h77; mem[8'h20] = 8'h3C; mem[8'h21] = 8'hC3; mem[8'h00] = 8'h44;
    repeat (3) @(negedge clk);
    chk("rst_req", 32'(reg_req), 0);
    chk("rst_outs", {tx_byte, reg_addr, reg_wdata, 8'({tx_valid, hold_clock_low, reg_we, err_timeout, err_overrun})}, 0);
    rst_n = 1'b1;

    ack_delay = 2; hold_cnt = 0; ops = 0;
    do_start(1'b0);
    do_byte(8'h10);
    push_bus(1'b1, 8'h10, 8'hA5);
    do_byte(8'hA5);
    wait_bus("wr0");
    push_bus(1'b1, 8'h11, 8'h5A);
    do_byte(8'h5A);
    wait_bus("wr1");
    do_stop();
    chk("wr_hold_cycles", 32'(hold_cnt), 6);
    chk("wr_hold_low", 32'(hold_clock_low), 0);
    chk("wr_ops", 32'(ops), 2);
    chk("wr_mem10", 32'(mem[8'h10]), 32'hA5);
    chk("wr_mem11", 32'(mem[8'h11]), 32'h5A);
    push_bus(1'b0, 8'h12, 8'h00); exp_tx.push_back(8'h77);
    do_start(1'b1);
    wait_bus("ptr12");
    check_tx("ptr12");
    do_nack(); do_stop();

    ops = 0;
    do_start(1'b0);
    do_byte(8'h20);
    push_bus(1'b0, 8'h20, 8'h00); exp_tx.push_back(8'h3C);
    do_start(1'b1);
    wait_bus("rd0");
    check_tx("rd0");
    push_bus(1'b0, 8'h21, 8'h00); exp_tx.push_back(8'hC3);
    do_txreq();
    chk("rd_txvalid_drop", 32'(tx_valid), 0);
    chk("rd_prefetch_req", 32'(reg_req), 1);
    wait_bus("rd1");
    check_tx("rd1");
    do_nack();
    repeat (20) @(negedge clk);
    chk("rd_ops", 32'(ops), 2);
    chk("rd_done_req", 32'(reg_req), 0);
    chk("rd_done_txvalid", 32'(tx_valid), 0);
    do_stop();

    do_start(1'b0);
    do_byte(8'hFF);
    push_bus(1'b1, 8'hFF, 8'h99);
    do_byte(8'h99);
    wait_bus("wrap_wr");
    chk("wrap_memff", 32'(mem[8'hFF]), 32'h99);
    do_stop();
    push_bus(1'b0, 8'h00, 8'h00); exp_tx.push_back(8'h44);
    do_start(1'b1);
    wait_bus("wrap_rd");
    check_tx("wrap_rd");
    do_nack(); do_stop();

    ack_en = 1'b0;
    do_start(1'b0);
    do_byte(8'h30);
    do_byte(8'h12);
    repeat (200) @(negedge clk);
    chk("to_still_req", 32'(reg_req), 1);
    chk("to_still_hold", 32'(hold_clock_low), 1);
    wait_bus("to");
    chk("to_err", 32'(err_timeout), 1);
    @(negedge clk);
    chk("to_hold_released", 32'(hold_clock_low), 0);
    ack_en = 1'b1;
    do_stop();
    chk("to_err_sticky", 32'(err_timeout), 1);
    do_start(1'b0);
    chk("to_err_cleared", 32'(err_timeout), 0);
    do_stop();

    ack_delay = 10; ops = 0;
    do_start(1'b0);
    do_byte(8'h40);
    push_bus(1'b1, 8'h40, 8'h66);
    do_byte(8'h66);
    do_stop();
    do_byte(8'hEE);
    chk("stop_req_held", 32'(reg_req), 1);
    wait_bus("stop");
    chk("stop_mem40", 32'(mem[8'h40]), 32'h66);
    chk("ovr_err", 32'(err_overrun), 1);
    do_byte(8'h55);
    repeat (3) @(negedge clk);
    chk("stop_idle_ops", 32'(ops), 1);
    chk("stop_idle_req", 32'(reg_req), 0);
    do_start(1'b0);
    chk("ovr_err_cleared", 32'(err_overrun), 0);
    do_stop();

    ack_en = 1'b0; ack_delay = 0;
    do_start(1'b0);
    do_byte(8'h50);
    do_start(1'b1);
    repeat (3) @(negedge clk);
    chk("rst_mid_req_before", 32'(reg_req), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_req", 32'(reg_req), 0);
    chk("rst_mid_hold", 32'(hold_clock_low), 0);
    chk("rst_mid_outs", {tx_byte, reg_addr, reg_wdata, 8'({tx_valid, reg_we, err_timeout, err_overrun})}, 0);
    @(negedge clk); rst_n = 1'b1; ack_en = 1'b1;
    push_bus(1'b0, 8'h00, 8'h00); exp_tx.push_back(8'h44);
    do_start(1'b1);
    wait_bus("rst_rd");
    check_tx("rst_rd");
    do_nack(); do_stop();
    repeat (3) @(negedge clk);
    chk("bus_queue_drained", 32'(exp_bus.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
